// File: rtl/encode_8b10b.sv
// encode_8b10b: registered 8b/10b line encoder (IEEE 802.3 Clause 36 tables).
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous, active-high reset
//   datain   [8] = K flag, [7:0] = HGFEDCBA (A is bit 0)
//   dispin   running disparity before this character (0 = RD-, 1 = RD+)
//   dataout  encoded symbol {j,h,g,f,i,e,d,c,b,a}, bit 0 sent first
//   dispout  running disparity after this symbol
//   kerr     illegal control-code flag
//
// Optional feature: define ENCODE_KERR_EN to register kerr for illegal K
// codes. Without it kerr is tied low. Illegal K codes are always encoded as
// data characters.
module encode_8b10b (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] datain,
    input  logic       dispin,
    output logic [9:0] dataout,
    output logic       dispout,
    output logic       kerr
);

    logic [4:0] x;
    logic [2:0] y;
    logic       k28;
    logic       legal_k;
    logic       k;

    assign x   = datain[4:0];
    assign y   = datain[7:5];
    assign k28 = (x == 5'd28);

    // Only K28.y and K23/27/29/30.7 exist; anything else is encoded as data.
    assign legal_k = k28 | ((y == 3'd7) &
                     ((x == 5'd23) | (x == 5'd27) | (x == 5'd29) | (x == 5'd30)));
    assign k       = datain[8] & legal_k;

    // ---------------- 5b/6b ----------------
    // s6_base holds the RD- form as {a,b,c,d,e,i}, a at the MSB.
    logic [5:0] s6_base;
    logic [5:0] s6;
    logic       unbal6;
    logic       disp6;

    always_comb begin
        s6_base = 6'b000000;
        case (x)
            5'd0:  s6_base = 6'b100111;
            5'd1:  s6_base = 6'b011101;
            5'd2:  s6_base = 6'b101101;
            5'd3:  s6_base = 6'b110001;
            5'd4:  s6_base = 6'b110101;
            5'd5:  s6_base = 6'b101001;
            5'd6:  s6_base = 6'b011001;
            5'd7:  s6_base = 6'b111000;
            5'd8:  s6_base = 6'b111001;
            5'd9:  s6_base = 6'b100101;
            5'd10: s6_base = 6'b010101;
            5'd11: s6_base = 6'b110100;
            5'd12: s6_base = 6'b001101;
            5'd13: s6_base = 6'b101100;
            5'd14: s6_base = 6'b011100;
            5'd15: s6_base = 6'b010111;
            5'd16: s6_base = 6'b011011;
            5'd17: s6_base = 6'b100011;
            5'd18: s6_base = 6'b010011;
            5'd19: s6_base = 6'b110010;
            5'd20: s6_base = 6'b001011;
            5'd21: s6_base = 6'b101010;
            5'd22: s6_base = 6'b011010;
            5'd23: s6_base = 6'b111010;
            5'd24: s6_base = 6'b110011;
            5'd25: s6_base = 6'b100110;
            5'd26: s6_base = 6'b010110;
            5'd27: s6_base = 6'b110110;
            5'd28: s6_base = 6'b001110;
            5'd29: s6_base = 6'b101110;
            5'd30: s6_base = 6'b011110;
            default: s6_base = 6'b101011;
        endcase
        if (k && k28)
            s6_base = 6'b001111;
    end

    assign unbal6 = ($countones(s6_base) != 3);
    // D.7 is balanced but still alternates its form to bound run length;
    // it does not move the running disparity.
    assign s6     = ((unbal6 | (x == 5'd7)) & dispin) ? ~s6_base : s6_base;
    assign disp6  = dispin ^ unbal6;

    // ---------------- 3b/4b ----------------
    // f4_base holds the RD- form as {f,g,h,j}, f at the MSB.
    logic       use_a7;
    logic       kcomp;
    logic [3:0] f4_base;
    logic [3:0] f4;
    logic       unbal4;

    // A7 avoids a run of five equal bits across the 6b/4b boundary.
    assign use_a7 = (y == 3'd7) &
                    (k |
                     (~disp6 & ((x == 5'd17) | (x == 5'd18) | (x == 5'd20))) |
                     ( disp6 & ((x == 5'd11) | (x == 5'd13) | (x == 5'd14))));

    always_comb begin
        f4_base = 4'b0000;
        case (y)
            3'd0: f4_base = 4'b1011;
            3'd1: f4_base = 4'b1001;
            3'd2: f4_base = 4'b0101;
            3'd3: f4_base = 4'b1100;
            3'd4: f4_base = 4'b1101;
            3'd5: f4_base = 4'b1010;
            3'd6: f4_base = 4'b0110;
            default: f4_base = use_a7 ? 4'b0111 : 4'b1110;
        endcase
    end

    assign unbal4 = ($countones(f4_base) != 2);
    // K28 balanced sub-blocks flip when the 6b block left RD-, keeping the
    // comma and K28 symbols distinct from any data symbol.
    assign kcomp  = k & k28 & ~disp6 &
                    ((y == 3'd1) | (y == 3'd2) | (y == 3'd5) | (y == 3'd6));
    assign f4     = (((unbal4 | (y == 3'd3)) & disp6) | kcomp) ? ~f4_base : f4_base;

    // ---------------- output register ----------------
    logic [9:0] sym;
    logic       disp_next;

    assign sym       = {f4[0], f4[1], f4[2], f4[3],
                        s6[0], s6[1], s6[2], s6[3], s6[4], s6[5]};
    assign disp_next = disp6 ^ unbal4;

    always_ff @(posedge clk) begin
        if (reset) begin
            dataout <= 10'h000;
            dispout <= 1'b0;
        end else begin
            dataout <= sym;
            dispout <= disp_next;
        end
    end

`ifdef ENCODE_KERR_EN
    always_ff @(posedge clk) begin
        if (reset)
            kerr <= 1'b0;
        else
            kerr <= datain[8] & ~legal_k;
    end
`else
    assign kerr = 1'b0;
`endif

endmodule

// File: tb/tb_encode_8b10b.sv
// tb_encode_8b10b: directed vector table plus randomized stream against a
// table-lookup reference model of the 8b/10b code.
module tb_encode_8b10b;

`ifdef ENCODE_KERR_EN
    localparam bit KERR_EN = 1'b1;
`else
    localparam bit KERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] datain;
    logic       dispin;
    logic [9:0] dataout;
    logic       dispout;
    logic       kerr;

    int checks = 0;
    int errors = 0;

    encode_8b10b dut (
        .clk     (clk),
        .reset   (reset),
        .datain  (datain),
        .dispin  (dispin),
        .dataout (dataout),
        .dispout (dispout),
        .kerr    (kerr)
    );

    always #5 clk = ~clk;

    // Standard code tables, both RD columns written out ({a..i}, {f..j}).
    localparam logic [5:0] T6N [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
    localparam logic [5:0] T6P [32] = '{
        6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
        6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
        6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
        6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
    localparam logic [3:0] T4N [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100,
                                       4'b1101, 4'b1010, 4'b0110, 4'b1110};
    localparam logic [3:0] T4P [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011,
                                       4'b0010, 4'b1010, 4'b0110, 4'b0001};
    // K28.y 4b forms, indexed by the disparity left by the 6b block.
    localparam logic [3:0] K4N [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100,
                                       4'b1101, 4'b0101, 4'b1001, 4'b0111};
    localparam logic [3:0] K4P [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011,
                                       4'b0010, 4'b1010, 4'b0110, 4'b1000};

    function automatic void model(input logic [8:0] d, input logic rd,
                                  output logic [9:0] sym, output logic rdo,
                                  output logic ke);
        int x = int'(d[4:0]);
        int y = int'(d[7:5]);
        bit legal = (x == 28) || (y == 7 && (x inside {23, 27, 29, 30}));
        bit kk = d[8] && legal;
        logic [5:0] s6;
        logic [3:0] f4;
        logic rd6;
        if (kk && x == 28) s6 = rd ? 6'b110000 : 6'b001111;
        else               s6 = rd ? T6P[x] : T6N[x];
        rd6 = rd ^ ($countones(s6) != 3);
        if (kk && x == 28)
            f4 = rd6 ? K4P[y] : K4N[y];
        else if (y == 7 && (kk || (!rd6 && (x inside {17, 18, 20})) ||
                                  (rd6 && (x inside {11, 13, 14}))))
            f4 = rd6 ? 4'b1000 : 4'b0111;
        else
            f4 = rd6 ? T4P[y] : T4N[y];
        for (int i = 0; i < 6; i++) sym[i]     = s6[5 - i];
        for (int i = 0; i < 4; i++) sym[6 + i] = f4[3 - i];
        rdo = rd ^ ($countones(sym) != 5);
        ke  = KERR_EN && d[8] && !legal;
    endfunction

    task automatic check(input string name, input logic [9:0] ed,
                         input logic es, input logic ek);
        checks++;
        if (dataout !== ed || dispout !== es || kerr !== ek) begin
            errors++;
            $display("FAIL %s: got dataout=%h dispout=%b kerr=%b, expected dataout=%h dispout=%b kerr=%b",
                     name, dataout, dispout, kerr, ed, es, ek);
        end
    endtask

    typedef struct {
        string      name;
        logic       rst;
        logic [8:0] din;
        logic       dis;
        logic [9:0] dout;
        logic       dsp;
        logic       ke;
    } vec_t;

    vec_t vecs [16];

    initial begin
        logic [9:0] esym;
        logic       erd;
        logic       ek;
        logic       mrd;
        logic       rst_r;

        vecs[0]  = '{"reset0",   1'b1, 9'h1BC, 1'b1, 10'h000, 1'b0, 1'b0};
        vecs[1]  = '{"reset1",   1'b1, 9'h0A5, 1'b0, 10'h000, 1'b0, 1'b0};
        vecs[2]  = '{"K28.5-",   1'b0, 9'h1BC, 1'b0, 10'h17C, 1'b1, 1'b0};
        vecs[3]  = '{"K28.5+",   1'b0, 9'h1BC, 1'b1, 10'h283, 1'b0, 1'b0};
        vecs[4]  = '{"D0.0-",    1'b0, 9'h000, 1'b0, 10'h0B9, 1'b0, 1'b0};
        vecs[5]  = '{"D21.5-",   1'b0, 9'h0B5, 1'b0, 10'h155, 1'b0, 1'b0};
        vecs[6]  = '{"D21.5+",   1'b0, 9'h0B5, 1'b1, 10'h155, 1'b1, 1'b0};
        vecs[7]  = '{"D17.7-A7", 1'b0, 9'h0F1, 1'b0, 10'h3B1, 1'b1, 1'b0};
        vecs[8]  = '{"K0.0bad",  1'b0, 9'h100, 1'b0, 10'h0B9, 1'b0, KERR_EN};
        vecs[9]  = '{"K28.7-",   1'b0, 9'h1FC, 1'b0, 10'h07C, 1'b0, 1'b0};
        vecs[10] = '{"K23.7-",   1'b0, 9'h1F7, 1'b0, 10'h057, 1'b0, 1'b0};
        vecs[11] = '{"D11.7+A7", 1'b0, 9'h0EB, 1'b1, 10'h04B, 1'b0, 1'b0};
        vecs[12] = '{"D7.3+",    1'b0, 9'h067, 1'b1, 10'h338, 1'b1, 1'b0};
        vecs[13] = '{"K17.7bad", 1'b0, 9'h1F1, 1'b0, 10'h3B1, 1'b1, KERR_EN};
        vecs[14] = '{"K28.5b",   1'b0, 9'h1BC, 1'b0, 10'h17C, 1'b1, 1'b0};
        vecs[15] = '{"midreset", 1'b1, 9'h0F1, 1'b0, 10'h000, 1'b0, 1'b0};

        reset  = 1'b1;
        datain = 9'h000;
        dispin = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            reset  = vecs[i].rst;
            datain = vecs[i].din;
            dispin = vecs[i].dis;
            @(posedge clk);
            #1;
            check(vecs[i].name, vecs[i].dout, vecs[i].dsp, vecs[i].ke);
        end

        // Random stream: disparity follows the model, with occasional forced
        // flips, K codes biased towards legal ones, and sporadic resets.
        mrd = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            logic [8:0] d;
            logic       r;
            d = 9'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                d[8] = 1'b1;
                case ($urandom_range(0, 2))
                    0: d[4:0] = 5'd28;
                    1: begin
                        d[7:5] = 3'd7;
                        case ($urandom_range(0, 3))
                            0: d[4:0] = 5'd23;
                            1: d[4:0] = 5'd27;
                            2: d[4:0] = 5'd29;
                            default: d[4:0] = 5'd30;
                        endcase
                    end
                    default: ;
                endcase
            end else begin
                d[8] = 1'b0;
            end
            if ($urandom_range(0, 9) == 0) mrd = ~mrd;
            r = ($urandom_range(0, 49) == 0);
            reset  = r;
            datain = d;
            dispin = mrd;
            model(d, mrd, esym, erd, ek);
            rst_r = r;
            @(posedge clk);
            #1;
            if (rst_r) begin
                check("rand_reset", 10'h000, 1'b0, 1'b0);
                mrd = 1'b0;
            end else begin
                check("rand", esym, erd, ek);
                mrd = erd;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
